// File: rtl/ram2e_gen2.sv
// RAM2E bank-switching DRAM sequencer: PHI1-locked phase counter drives RAS/CAS/high address.
// Strobes and RA are registered one C14M edge after their phase; data-bus steering is combinational.
module ram2e_gen2 #(
  parameter int                BANK_W     = 6,
  parameter int                RAH_W      = 4,
  parameter logic [BANK_W-1:0] BANK_MASK  = '1,
  parameter int                REF_PERIOD = 13
) (
  input  logic             C14M,
  input  logic             RST,
  input  logic             PHI1,
  input  logic             nPRAS,
  input  logic             nWE,
  input  logic             nWE80,
  input  logic             nEN80,
  input  logic             nC07X,
  input  logic [7:0]       MA,
  inout  wire  [7:0]       MD,
  inout  wire  [7:0]       RD,
  inout  wire  [7:0]       VD,
  output logic             nRAS,
  output logic             nCAS,
  output logic             nRWE,
  output logic [RAH_W-1:0] RA
);

  localparam int         BPW      = 2 * RAH_W;
  localparam int         XW       = (BANK_W > 8) ? BANK_W : 8;
  localparam logic [7:0] REF_LAST = 8'(REF_PERIOD - 1);

  logic [3:0]        s_q, s_d;
  logic [7:0]        ref_q, ref_d;
  logic              phi0seen_q, phi0seen_d;
  logic              phi1_prev_q, phi1_prev_d;
  logic              selw_q, selw_d;
  logic              selr_q, selr_d;
  logic [BANK_W-1:0] ba_q, ba_d;
  logic [7:0]        vdr_q, vdr_d;
  logic [RAH_W-1:0]  ra_q, ra_d;
  logic              nras_q, nras_d;
  logic              ncas_q, ncas_d;

  logic              s_load;
  logic              sel_hit;
  logic [BPW-1:0]    ba_pad;
  logic [XW-1:0]     ba_x;
  logic [XW-1:0]     md_x;
  logic              md_rb_oe, md_rd_oe, rd_oe;
  logic              unused_in;

  assign ba_pad    = BPW'(ba_q);
  assign ba_x      = XW'(ba_q);
  assign md_x      = XW'(MD);
  assign sel_hit   = !nC07X && (MA[3:0] == 4'h3);
  assign unused_in = ^{MA[7:4], md_x};

  always_comb begin
    s_load      = PHI1 && !phi1_prev_q && phi0seen_q;
    s_d         = s_q;
    ref_d       = ref_q;
    phi0seen_d  = phi0seen_q | ~PHI1;
    phi1_prev_d = PHI1;
    selw_d      = selw_q;
    selr_d      = selr_q;
    ba_d        = ba_q;
    vdr_d       = vdr_q;
    ra_d        = '0;
    ncas_d      = ncas_q;

    if (s_load) begin
      s_d = 4'd1;
    end else if (s_q != 4'd0 && s_q != 4'd15) begin
      s_d = s_q + 4'd1;
    end

    if (s_q == 4'd1) begin
      ref_d = (ref_q == REF_LAST) ? 8'd0 : ref_q + 8'd1;
    end

    nras_d = !(s_load || (s_q inside {4'd1, 4'd2, 4'd7, 4'd8, 4'd9, 4'd10}) ||
               (s_q == 4'd5 && ref_q == 8'd0));

    if (s_q inside {4'd2, 4'd4, 4'd10}) ncas_d = 1'b0;
    // Precharge must beat a CAS request so a restarted sequence never leaves CAS stuck low.
    if (s_q == 4'd0 || s_q == 4'd3 || nPRAS) ncas_d = 1'b1;

    if (s_q inside {4'd6, 4'd7, 4'd8}) begin
      ra_d = ba_pad[BPW-1:RAH_W];
    end else if (s_q inside {4'd9, 4'd10}) begin
      ra_d = ba_pad[RAH_W-1:0];
    end

    if (s_load) begin
      selw_d = 1'b0;
      selr_d = 1'b0;
    end else if (s_q == 4'd7) begin
      selw_d = sel_hit && !nWE;
      selr_d = sel_hit && nWE;
    end

    if (s_q == 4'd13 && selw_q) ba_d = md_x[BANK_W-1:0] & BANK_MASK;
    if (s_q == 4'd3) vdr_d = RD;
  end

  always_ff @(posedge C14M) begin
    if (RST) begin
      s_q         <= '0;
      ref_q       <= '0;
      phi0seen_q  <= 1'b0;
      phi1_prev_q <= 1'b0;
      selw_q      <= 1'b0;
      selr_q      <= 1'b0;
      ba_q        <= '0;
      vdr_q       <= '0;
      ra_q        <= '0;
      nras_q      <= 1'b1;
      ncas_q      <= 1'b1;
    end else begin
      s_q         <= s_d;
      ref_q       <= ref_d;
      phi0seen_q  <= phi0seen_d;
      phi1_prev_q <= phi1_prev_d;
      selw_q      <= selw_d;
      selr_q      <= selr_d;
      ba_q        <= ba_d;
      vdr_q       <= vdr_d;
      ra_q        <= ra_d;
      nras_q      <= nras_d;
      ncas_q      <= ncas_d;
    end
  end

  // Bank readback owns MD outright; the RD pass-through only applies when it is idle.
  assign md_rb_oe = selr_q && nWE;
  assign md_rd_oe = !md_rb_oe && !nEN80 && nWE;
  assign rd_oe    = !md_rb_oe && !nEN80 && !nWE;

  assign MD   = md_rb_oe ? ba_x[7:0] : (md_rd_oe ? RD : 8'hzz);
  assign RD   = rd_oe ? MD : 8'hzz;
  assign VD   = PHI1 ? 8'hzz : vdr_q;
  assign nRWE = nWE80;
  assign nRAS = nras_q;
  assign nCAS = ncas_q;
  assign RA   = ra_q;

endmodule

// File: tb/tb_ram2e_gen2.sv
// Directed bench for ram2e_gen2: PHI1 cycles of 28 C14M edges, bank write/readback, refresh, reset abort.
module tb_ram2e_gen2;

  localparam int RAH_W = 4;
  localparam logic [27:0] PHI_NORM   = 28'h0003FFF;
  localparam logic [27:0] PRAS_NORM  = 28'hFFFF001;
  localparam logic [27:0] RAS_NOREF  = 28'hFFFF878;
  localparam logic [27:0] RAS_REF    = 28'hFFFF858;
  localparam logic [27:0] CAS_NORM   = 28'hFFFF00B;

  logic             C14M = 1'b0;
  logic             RST, PHI1, nPRAS, nWE, nWE80, nEN80, nC07X;
  logic [7:0]       MA;
  logic [7:0]       md_drv, rd_drv;
  logic             md_en, rd_en;
  wire  [7:0]       md, rd, vd;
  logic             nRAS, nCAS, nRWE;
  logic [RAH_W-1:0] RA;

  assign md = md_en ? md_drv : 8'hzz;
  assign rd = rd_en ? rd_drv : 8'hzz;

  int vec_cnt = 0;
  int err_cnt = 0;
  int gc = 0;
  int nref = 0;

  logic [63:0] ras_obs, cas_obs;
  logic [3:0]  ra_obs [64];
  logic [7:0]  md_obs [64];
  logic [7:0]  rd_obs [64];
  logic [7:0]  vd_obs [64];

  ram2e_gen2 #(
    .BANK_W    (6),
    .RAH_W     (RAH_W),
    .BANK_MASK (6'h1F),
    .REF_PERIOD(3)
  ) dut (
    .C14M  (C14M),
    .RST   (RST),
    .PHI1  (PHI1),
    .nPRAS (nPRAS),
    .nWE   (nWE),
    .nWE80 (nWE80),
    .nEN80 (nEN80),
    .nC07X (nC07X),
    .MA    (MA),
    .MD    (md),
    .RD    (rd),
    .VD    (vd),
    .nRAS  (nRAS),
    .nCAS  (nCAS),
    .nRWE  (nRWE),
    .RA    (RA)
  );

  always #5 C14M = ~C14M;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_seq(input int n, input logic [63:0] phi_pat, input logic [63:0] pras_pat);
    ras_obs = '1;
    cas_obs = '1;
    for (int i = 0; i < n; i++) begin
      PHI1  = phi_pat[i];
      nPRAS = pras_pat[i];
      @(posedge C14M);
      #1;
      ras_obs[i] = nRAS;
      cas_obs[i] = nCAS;
      ra_obs[i]  = RA;
      md_obs[i]  = md;
      rd_obs[i]  = rd;
      vd_obs[i]  = vd;
    end
  endtask

  // Host drives MD on writes; the DRAM model drives RD on reads.
  task automatic set_bus(input logic sel, input logic we_n, input logic en80_n,
                         input logic [7:0] mdv, input logic [7:0] rdv);
    nC07X  = ~sel;
    MA     = sel ? 8'h73 : 8'h00;
    nWE    = we_n;
    nEN80  = en80_n;
    md_drv = mdv;
    md_en  = ~we_n;
    rd_drv = rdv;
    rd_en  = we_n;
  endtask

  task automatic cycle();
    run_seq(28, 64'(PHI_NORM), 64'(PRAS_NORM));
    gc++;
    chk($sformatf("ras_c%0d", gc), ras_obs[27:0], (gc % 3 == 0) ? RAS_REF : RAS_NOREF);
    chk($sformatf("cas_c%0d", gc), cas_obs[27:0], CAS_NORM);
  endtask

  initial begin
    RST   = 1'b1;
    PHI1  = 1'b1;
    nPRAS = 1'b1;
    nWE80 = 1'b1;
    set_bus(1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    repeat (3) @(posedge C14M);
    #1;
    chk("rst_nras", nRAS, 1);
    chk("rst_ncas", nCAS, 1);
    chk("rst_ra", RA, 0);
    chk("rst_s", dut.s_q, 0);
    nWE80 = 1'b0;
    #1 chk("nrwe_lo", nRWE, 0);
    nWE80 = 1'b1;
    #1 chk("nrwe_hi", nRWE, 1);
    RST = 1'b0;

    // PHI1 high from reset with no low phase: no DRAM cycle may start.
    run_seq(20, '1, '1);
    chk("nophi0_ras", ras_obs[19:0], 20'hFFFFF);
    chk("nophi0_cas", cas_obs[19:0], 20'hFFFFF);
    chk("nophi0_s", dut.s_q, 0);
    run_seq(14, '0, '1);
    chk("prep_ras", ras_obs[13:0], 14'h3FFF);

    // Nine plain cycles; REF_PERIOD=3 gives refresh RAS on cycles 3, 6, 9.
    repeat (9) begin
      cycle();
      if (ras_obs[5] == 1'b0) nref++;
    end
    chk("ref_count", nref, 3);

    set_bus(1'b1, 1'b0, 1'b1, 8'h2A, 8'h00);
    cycle();
    chk("wr2a_ra9", ra_obs[9], 0);

    set_bus(1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    cycle();
    chk("ba0a_ra5", ra_obs[5], 4'h0);
    chk("ba0a_ra6", ra_obs[6], 4'h0);
    chk("ba0a_ra8", ra_obs[8], 4'h0);
    chk("ba0a_ra9", ra_obs[9], 4'hA);
    chk("ba0a_ra10", ra_obs[10], 4'hA);
    chk("ba0a_ra11", ra_obs[11], 4'h0);

    set_bus(1'b1, 1'b1, 1'b0, 8'h00, 8'h55);
    cycle();
    chk("rd_path_md3", md_obs[3], 8'h55);
    chk("readback_md12", md_obs[12], 8'h0A);
    chk("readback_md27", md_obs[27], 8'h0A);
    chk("vd_latch55", vd_obs[20], 8'h55);
    chk("rdcyc_ra9", ra_obs[9], 4'hA);

    set_bus(1'b1, 1'b0, 1'b1, 8'h3F, 8'h00);
    cycle();

    set_bus(1'b1, 1'b1, 1'b1, 8'h00, 8'h66);
    cycle();
    chk("ba1f_ra6", ra_obs[6], 4'h1);
    chk("ba1f_ra8", ra_obs[8], 4'h1);
    chk("ba1f_ra9", ra_obs[9], 4'hF);
    chk("ba1f_ra11", ra_obs[11], 4'h0);
    chk("readback_1f", md_obs[12], 8'h1F);
    chk("vd_latch66", vd_obs[20], 8'h66);

    set_bus(1'b0, 1'b0, 1'b0, 8'hC3, 8'h00);
    cycle();
    chk("wr_path_rd5", rd_obs[5], 8'hC3);
    chk("vd_latchc3", vd_obs[20], 8'hC3);

    // Bank write of $15 aborted by reset on the S=12 edge.
    set_bus(1'b1, 1'b0, 1'b1, 8'h15, 8'h00);
    run_seq(12, 64'(PHI_NORM), 64'(PRAS_NORM));
    chk("abort_cas_pre", cas_obs[11], 0);
    RST   = 1'b1;
    PHI1  = 1'b1;
    nPRAS = 1'b0;
    @(posedge C14M);
    #1;
    chk("abort_nras", nRAS, 1);
    chk("abort_ncas", nCAS, 1);
    chk("abort_ra", RA, 0);
    RST = 1'b0;
    set_bus(1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    run_seq(14, '0, '1);
    chk("post_rst_ras", ras_obs[13:0], 14'h3FFF);

    // PHI1 re-rises at S=6: sequence restarts at 1 and CAS rises again at S=3.
    run_seq(16, 64'h000000000000FFCF, 64'h0);
    chk("restart_ras", ras_obs[15:0], 16'h1E38);
    chk("restart_cas", cas_obs[15:0], 16'h020B);

    run_seq(14, '0, '1);
    set_bus(1'b1, 1'b1, 1'b1, 8'h00, 8'h99);
    run_seq(28, 64'(PHI_NORM), 64'(PRAS_NORM));
    chk("post_abort_ba", md_obs[12], 8'h00);
    chk("post_abort_ras", ras_obs[27:0], RAS_REF);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
